multi_mod_cnt: RTL
==================

# multi_mod_cnt

Parametrised bank of NUM_CH independent modulo counters with per-channel run-time modulus, enable, clear and terminal-count pulse, plus an optional cascade mode that chains each channel's wrap into the next. Cross-channel comparison outputs (all-equal flag, index of the largest count) generalise the two-counter A/B compare of the earlier lab block. Sits in the lab designs as the counter core, with modulus and control driven from an in-system source probe and outputs sent to a probe/logic analyser.

## Interface
- NUM_CH, 4: number of counter channels (≥2).
- WIDTH, 10: counter and modulus width in bits (≥2).
- IDXW, $clog2(NUM_CH): width of max_idx (derived, local).

- CLK  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel count enable.
- clr  in  NUM_CH  per-channel synchronous clear of count (modulus kept).
- cascade  in  1  0: channels independent; 1: channel i>0 steps only on wrap of channel i-1.
- mod_in  in  NUM_CH*WIDTH  modulus for channel i at bits [i*WIDTH +: WIDTH].
- mod_ld  in  NUM_CH  load mod_in slice into channel modulus register.
- cnt  out  NUM_CH*WIDTH  current counts, same packing as mod_in.
- cout  out  NUM_CH  registered one-cycle wrap pulse per channel.
- all_eq  out  1  all counts equal.
- max_idx  out  IDXW  index of channel with largest count.

## Operation
- Modulus M per channel: count runs 0..M-1. M=0 encodes 2^WIDTH (full range). M=1: count stays 0, every step is a wrap.
- Reset values: every cnt=0, every modulus register=0 (full range), cout=0; hence all_eq=1, max_idx=0 after reset.
- step[i]: independent mode = en[i]; cascade mode = en[0] for i=0, en[i] & wrap[i-1] for i>0.
- wrap[i] = step[i] & (cnt[i] == M[i]-1, modulo 2^WIDTH). Wrap chain is combinational across all channels within one cycle.
- Per-channel priority each cycle: rst > clr[i] > mod_ld[i] > step[i].
  - clr[i]: cnt[i]←0; no wrap, cout[i] not asserted next cycle.
  - mod_ld[i]: M[i]←slice; cnt[i]←0 if new M≠0 and cnt[i] ≥ new M, else cnt[i] held; no step, no wrap this cycle.
  - step without wrap: cnt[i]←cnt[i]+1. Step with wrap: cnt[i]←0.
- A channel blocked by clr/mod_ld produces wrap=0, so in cascade downstream channels do not step that cycle.
- cout[i] registered: next-cycle value = wrap[i]; cleared by rst.
- all_eq, max_idx: combinational from the cnt registers only (not from inputs). max_idx ties resolve to lowest index.
- Toggling cascade takes effect the same cycle; counts are not altered.

## Timing
- cnt latency: input change → cnt update at next CLK edge (1 cycle).
- cout: high exactly in the cycle cnt[i] shows 0 after a wrap; width one cycle per wrap; with M=1 and en held, cout stays high continuously.
- all_eq/max_idx valid in the same cycle as the cnt value they describe.
- rst asserted mid-count: all state cleared at that edge regardless of other inputs; first step possible the cycle after rst deasserts.
- Full-range (M=0): wrap at cnt=2^WIDTH-1 → 0.

## Test plan
- Reset/defaults: rst 2 cycles, then en=0 → cnt all 0, cout=0, all_eq=1, max_idx=0; en=4'b0001 for 1024 cycles → cnt[0] wraps 1023→0, cout[0] high one cycle.
- Independent modulus: load M={7,5,3,1} (ch3..ch0), en=4'b1111 for 21 cycles → ch1 cout every 3 cycles, ch0 cout every cycle, ch2 every 5, ch3 every 7; after 21 cycles cnt={0,1,0,0}; all_eq=0, max_idx=2.
- Cascade: M=10 all channels, cascade=1, en=4'b1111 → decimal counter; after 1234 cycles cnt={1,2,3,4} (ch3..ch0); on cycle 9999→0 all four cout high together.
- mod_ld shrink: ch0 M=100, count to 60, load M=50 → cnt[0]=0 next cycle, no cout; load M=80 at count 40 → holds 40 for the load cycle, then 41.
- Priority/simultaneous: ch1 at M-1 with en, clr[1]=1 and mod_ld[1]=1 same cycle → cnt[1]=0, cout[1]=0, in cascade ch2 does not step; then rst during running cascade → all cnt=0, cout=0 at that edge.
- Compare outputs: force counts {5,9,9,2} → max_idx=1 (lowest-index tie-break), all_eq=0; clr all → all_eq=1, max_idx=0.

Source files
------------

// File: rtl/multi_mod_cnt.sv
// Bank of NUM_CH run-time-modulus counters with optional wrap cascade,
// per-channel terminal-count pulse and cross-channel equal/maximum compare.
module multi_mod_cnt #(
    parameter int  NUM_CH = 4,
    parameter int  WIDTH  = 10,
    localparam int IDXW   = $clog2(NUM_CH)
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH-1:0]         clr,
    input  logic                      cascade,
    input  logic [NUM_CH*WIDTH-1:0]   mod_in,
    input  logic [NUM_CH-1:0]         mod_ld,
    output logic [NUM_CH*WIDTH-1:0]   cnt,
    output logic [NUM_CH-1:0]         cout,
    output logic                      all_eq,
    output logic [IDXW-1:0]           max_idx
);

    logic [NUM_CH-1:0] at_term;
    logic [NUM_CH-1:0] step;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] cout_reg;
    logic              carry;
    logic [WIDTH-1:0]  max_val;

    // Wrap chain is resolved in one pass so a carry can ripple through every
    // channel in the same cycle; a channel held by clr/mod_ld breaks the chain.
    always_comb begin
        step  = '0;
        wrap  = '0;
        carry = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            step[i] = en[i] & ((i == 0) || !cascade || carry);
            wrap[i] = step[i] & ~clr[i] & ~mod_ld[i] & at_term[i];
            carry   = wrap[i];
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] cnt_reg;
        logic [WIDTH-1:0] cnt_next;
        logic [WIDTH-1:0] mod_reg;
        logic [WIDTH-1:0] mod_next;
        logic [WIDTH-1:0] new_mod;

        assign new_mod = mod_in[gi*WIDTH +: WIDTH];
        // Modulus 0 means full range: 0 - 1 wraps to all ones.
        assign at_term[gi] = (cnt_reg == (mod_reg - WIDTH'(1)));

        always_comb begin
            cnt_next = cnt_reg;
            mod_next = mod_reg;
            if (clr[gi]) begin
                cnt_next = '0;
            end else if (mod_ld[gi]) begin
                mod_next = new_mod;
                if ((new_mod != '0) && (cnt_reg >= new_mod)) begin
                    cnt_next = '0;
                end
            end else if (wrap[gi]) begin
                cnt_next = '0;
            end else if (step[gi]) begin
                cnt_next = cnt_reg + WIDTH'(1);
            end
        end

        always_ff @(posedge CLK) begin
            if (rst) begin
                cnt_reg <= '0;
                mod_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
                mod_reg <= mod_next;
            end
        end

        assign cnt[gi*WIDTH +: WIDTH] = cnt_reg;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            cout_reg <= '0;
        end else begin
            cout_reg <= wrap;
        end
    end

    assign cout = cout_reg;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        all_eq  = 1'b1;
        max_idx = '0;
        max_val = cnt[WIDTH-1:0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (cnt[i*WIDTH +: WIDTH] != cnt[WIDTH-1:0]) begin
                all_eq = 1'b0;
            end
            if (cnt[i*WIDTH +: WIDTH] > max_val) begin
                max_val = cnt[i*WIDTH +: WIDTH];
                max_idx = IDXW'(i);
            end
        end
    end

endmodule
